// File: rtl/uart_message_receiver.sv
// ---------------------------------------------------------------------------
// uart_message_receiver
//
// Receive side of the board-to-board game link. The raw serial line is
// synchronised and oversampled (8N1, LSB first). Received bytes are assembled
// into link messages (ball / miss / new game / new-game ack). Each complete
// message is presented as one-hot type flags plus payload fields. It is held
// until the consumer acknowledges it.
//
// Optional feature: define COMM_CHECKSUM_EN to require a trailing checksum
// byte (XOR of all preceding bytes of the message). Without it a message is
// delivered on its last payload byte, or on its header when it has no payload.
//
// Ports:
//   clock                   system clock (CLOCK_50 domain)
//   reset_L                 asynchronous active-low reset
//   UART_RXD                raw serial input, idle high, asynchronous
//   message_acked           consumer has taken the current message
//   new_message_received    message valid, held until acked
//   ball_message_rx         ball message: ball_y_rx, velocity_x_rx, velocity_y_rx
//   miss_message_rx         miss message: my_score_rx, your_score_rx,
//                           you_should_serve_rx
//   new_game_message_rx     new-game message: you_serve_first_rx
//   new_game_ack_message_rx new-game acknowledgement
//   frame_error             1-cycle pulse, stop bit sampled low
//   bad_message             1-cycle pulse, bad header or checksum mismatch
//   message_dropped         1-cycle pulse, message lost while previous unacked
// ---------------------------------------------------------------------------
module uart_message_receiver #(
    parameter int CLKS_PER_BIT      = 434,
    parameter int IDLE_TIMEOUT_BITS = 20
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       UART_RXD,
    input  logic       message_acked,
    output logic       new_message_received,
    output logic       ball_message_rx,
    output logic [8:0] ball_y_rx,
    output logic [3:0] velocity_x_rx,
    output logic [3:0] velocity_y_rx,
    output logic       miss_message_rx,
    output logic [4:0] my_score_rx,
    output logic [4:0] your_score_rx,
    output logic       you_should_serve_rx,
    output logic       new_game_message_rx,
    output logic       you_serve_first_rx,
    output logic       new_game_ack_message_rx,
    output logic       frame_error,
    output logic       bad_message,
    output logic       message_dropped
);

    localparam int CNT_W          = $clog2(CLKS_PER_BIT);
    localparam int TIMEOUT_CYCLES = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]  TO_ZERO   = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        BIT_IDLE  = 2'd0,
        BIT_START = 2'd1,
        BIT_DATA  = 2'd2,
        BIT_STOP  = 2'd3
    } bit_state_t;

    typedef enum logic [2:0] {
        MSG_HDR     = 3'd0,
        MSG_PAY1    = 3'd1,
        MSG_PAY2    = 3'd2,
        MSG_CSUM    = 3'd3,
        MSG_DELIVER = 3'd4
    } msg_state_t;

    // A header is valid when its upper nibble is 0xA and bit 3 is clear.
    function automatic logic hdr_ok(input logic [7:0] b);
        return (b[7:3] == 5'b10100);
    endfunction

`ifdef COMM_CHECKSUM_EN
    // Running checksum: XOR of every byte of the message so far.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Input synchroniser and edge history
    // ------------------------------------------------------------------
    logic rx_meta_r;
    logic rx_sync_r;
    logic rx_prev_r;

    // Two-flop synchroniser on the asynchronous line plus one-cycle history for edge detect.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= UART_RXD;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // ------------------------------------------------------------------
    // Bit-level FSM
    // ------------------------------------------------------------------
    bit_state_t       bit_state_r, bit_state_s;
    logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             byte_valid_s;
    logic             frame_err_s;

    // Bit FSM state, oversampling counter and shift register.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            bit_state_r <= BIT_IDLE;
            bit_cnt_r   <= CNT_ZERO;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
        end else begin
            bit_state_r <= bit_state_s;
            bit_cnt_r   <= bit_cnt_s;
            bit_idx_r   <= bit_idx_s;
            shift_r     <= shift_s;
        end
    end

    // Bit FSM next state: start-bit qualification at half a bit, then mid-bit samples.
    always_comb begin
        bit_state_s  = bit_state_r;
        bit_cnt_s    = bit_cnt_r + CNT_ONE;
        bit_idx_s    = bit_idx_r;
        shift_s      = shift_r;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        case (bit_state_r)
            BIT_IDLE: begin
                bit_cnt_s = CNT_ZERO;
                if (rx_prev_r && !rx_sync_r) begin
                    bit_state_s = BIT_START;
                end else begin
                    bit_state_s = BIT_IDLE;
                end
            end
            BIT_START: begin
                if (bit_cnt_r == HALF_LAST) begin
                    bit_cnt_s = CNT_ZERO;
                    bit_idx_s = 3'd0;
                    // Line back high at mid start bit: a glitch, not a frame.
                    if (rx_sync_r) begin
                        bit_state_s = BIT_IDLE;
                    end else begin
                        bit_state_s = BIT_DATA;
                    end
                end else begin
                    bit_state_s = BIT_START;
                end
            end
            BIT_DATA: begin
                if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_s = CNT_ZERO;
                    shift_s   = {rx_sync_r, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        bit_state_s = BIT_STOP;
                    end else begin
                        bit_idx_s   = bit_idx_r + 3'd1;
                        bit_state_s = BIT_DATA;
                    end
                end else begin
                    bit_state_s = BIT_DATA;
                end
            end
            BIT_STOP: begin
                if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_s   = CNT_ZERO;
                    bit_state_s = BIT_IDLE;
                    if (rx_sync_r) begin
                        byte_valid_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end else begin
                    bit_state_s = BIT_STOP;
                end
            end
            default: begin
                bit_state_s = BIT_IDLE;
                bit_cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Message-level FSM
    // ------------------------------------------------------------------
    msg_state_t      msg_state_r, msg_state_s;
    logic [7:0]      hdr_r;
    logic [7:0]      pay1_r;
    logic [7:0]      pay2_r;
`ifdef COMM_CHECKSUM_EN
    logic [7:0]      csum_r;
`endif
    logic [TO_W-1:0] to_cnt_r;
    logic            timeout_s;
    logic            deliver_s;
    logic            bad_s;

    // Bytes of the message as seen at the completing edge; the byte just
    // received is still in the shift register, earlier ones are stored.
    logic [7:0] h_s;
    logic [7:0] p1_s;
    logic [7:0] p2_s;

    assign h_s  = (msg_state_r == MSG_HDR)  ? shift_r : hdr_r;
    assign p1_s = (msg_state_r == MSG_PAY1) ? shift_r : pay1_r;
    assign p2_s = (msg_state_r == MSG_PAY2) ? shift_r : pay2_r;

    assign timeout_s = (msg_state_r != MSG_HDR) && (msg_state_r != MSG_DELIVER) &&
                       (to_cnt_r == TO_LAST);

    // Message FSM state register.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            msg_state_r <= MSG_HDR;
        end else begin
            msg_state_r <= msg_state_s;
        end
    end

    // Line-silence counter; runs only while a message is partially assembled.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            to_cnt_r <= TO_ZERO;
        end else if ((msg_state_r == MSG_HDR) || (msg_state_r == MSG_DELIVER) ||
                     byte_valid_s || frame_err_s) begin
            to_cnt_r <= TO_ZERO;
        end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end
    end

    // Capture of header/payload bytes and the running checksum.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            hdr_r  <= 8'h00;
            pay1_r <= 8'h00;
            pay2_r <= 8'h00;
`ifdef COMM_CHECKSUM_EN
            csum_r <= 8'h00;
`endif
        end else if (byte_valid_s) begin
            case (msg_state_r)
                MSG_HDR: begin
                    hdr_r  <= shift_r;
`ifdef COMM_CHECKSUM_EN
                    csum_r <= shift_r;
`endif
                end
                MSG_PAY1: begin
                    pay1_r <= shift_r;
`ifdef COMM_CHECKSUM_EN
                    csum_r <= csum_step(csum_r, shift_r);
`endif
                end
                MSG_PAY2: begin
                    pay2_r <= shift_r;
`ifdef COMM_CHECKSUM_EN
                    csum_r <= csum_step(csum_r, shift_r);
`endif
                end
                default: begin
                    hdr_r <= hdr_r;
                end
            endcase
        end else begin
            hdr_r <= hdr_r;
        end
    end

    // Message FSM next state; framing errors and silence abandon the message.
    always_comb begin
        msg_state_s = msg_state_r;
        deliver_s   = 1'b0;
        bad_s       = 1'b0;
        if (frame_err_s) begin
            msg_state_s = MSG_HDR;
        end else if (byte_valid_s) begin
            case (msg_state_r)
                MSG_HDR: begin
                    if (!hdr_ok(shift_r)) begin
                        bad_s       = 1'b1;
                        msg_state_s = MSG_HDR;
                    end else begin
                        case (shift_r[1:0])
                            2'b00, 2'b01: begin
                                msg_state_s = MSG_PAY1;
                            end
                            default: begin
`ifdef COMM_CHECKSUM_EN
                                msg_state_s = MSG_CSUM;
`else
                                deliver_s   = 1'b1;
                                msg_state_s = MSG_DELIVER;
`endif
                            end
                        endcase
                    end
                end
                MSG_PAY1: begin
                    msg_state_s = MSG_PAY2;
                end
                MSG_PAY2: begin
`ifdef COMM_CHECKSUM_EN
                    msg_state_s = MSG_CSUM;
`else
                    deliver_s   = 1'b1;
                    msg_state_s = MSG_DELIVER;
`endif
                end
                MSG_CSUM: begin
`ifdef COMM_CHECKSUM_EN
                    if (shift_r == csum_r) begin
                        deliver_s   = 1'b1;
                        msg_state_s = MSG_DELIVER;
                    end else begin
                        bad_s       = 1'b1;
                        msg_state_s = MSG_HDR;
                    end
`else
                    msg_state_s = MSG_HDR;
`endif
                end
                default: begin
                    msg_state_s = MSG_HDR;
                end
            endcase
        end else if (timeout_s) begin
            msg_state_s = MSG_HDR;
        end else if (msg_state_r == MSG_DELIVER) begin
            msg_state_s = MSG_HDR;
        end else begin
            msg_state_s = msg_state_r;
        end
    end

    // ------------------------------------------------------------------
    // Field decode of the completing message (other types' fields stay 0)
    // ------------------------------------------------------------------
    logic       f_ball_s, f_miss_s, f_ng_s, f_ack_s;
    logic [8:0] f_y_s;
    logic [3:0] f_vx_s, f_vy_s;
    logic [4:0] f_my_s, f_your_s;
    logic       f_serve_s, f_first_s;

    // Decode header type and payload into output fields, sender/receiver scores swapped.
    always_comb begin
        f_ball_s  = 1'b0;
        f_miss_s  = 1'b0;
        f_ng_s    = 1'b0;
        f_ack_s   = 1'b0;
        f_y_s     = 9'd0;
        f_vx_s    = 4'd0;
        f_vy_s    = 4'd0;
        f_my_s    = 5'd0;
        f_your_s  = 5'd0;
        f_serve_s = 1'b0;
        f_first_s = 1'b0;
        case (h_s[1:0])
            2'b00: begin
                f_ball_s = 1'b1;
                f_y_s    = {h_s[2], p1_s};
                f_vx_s   = p2_s[3:0];
                f_vy_s   = p2_s[7:4];
            end
            2'b01: begin
                f_miss_s  = 1'b1;
                f_serve_s = p1_s[7];
                f_your_s  = p1_s[4:0];
                f_my_s    = p2_s[4:0];
            end
            2'b10: begin
                f_ng_s    = 1'b1;
                f_first_s = h_s[2];
            end
            2'b11: begin
                f_ack_s = 1'b1;
            end
            default: begin
                f_ack_s = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and registered outputs
    // ------------------------------------------------------------------
    logic ack_used_r;
    logic ack_s;

    // An ack is honoured once; the consumer must release it before it counts again.
    assign ack_s = message_acked && new_message_received && !ack_used_r;

    // Remembers that the current level of message_acked has already consumed a message.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            ack_used_r <= 1'b0;
        end else if (!message_acked) begin
            ack_used_r <= 1'b0;
        end else if (ack_s) begin
            ack_used_r <= 1'b1;
        end else begin
            ack_used_r <= ack_used_r;
        end
    end

    // Output message register: load, drop when still held, clear flags on ack.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            new_message_received    <= 1'b0;
            ball_message_rx         <= 1'b0;
            ball_y_rx               <= 9'd0;
            velocity_x_rx           <= 4'd0;
            velocity_y_rx           <= 4'd0;
            miss_message_rx         <= 1'b0;
            my_score_rx             <= 5'd0;
            your_score_rx           <= 5'd0;
            you_should_serve_rx     <= 1'b0;
            new_game_message_rx     <= 1'b0;
            you_serve_first_rx      <= 1'b0;
            new_game_ack_message_rx <= 1'b0;
            frame_error             <= 1'b0;
            bad_message             <= 1'b0;
            message_dropped         <= 1'b0;
        end else begin
            frame_error     <= frame_err_s;
            bad_message     <= bad_s;
            message_dropped <= 1'b0;
            if (deliver_s && (!new_message_received || ack_s)) begin
                new_message_received    <= 1'b1;
                ball_message_rx         <= f_ball_s;
                ball_y_rx               <= f_y_s;
                velocity_x_rx           <= f_vx_s;
                velocity_y_rx           <= f_vy_s;
                miss_message_rx         <= f_miss_s;
                my_score_rx             <= f_my_s;
                your_score_rx           <= f_your_s;
                you_should_serve_rx     <= f_serve_s;
                new_game_message_rx     <= f_ng_s;
                you_serve_first_rx      <= f_first_s;
                new_game_ack_message_rx <= f_ack_s;
            end else if (deliver_s) begin
                message_dropped <= 1'b1;
            end else if (ack_s) begin
                new_message_received    <= 1'b0;
                ball_message_rx         <= 1'b0;
                miss_message_rx         <= 1'b0;
                new_game_message_rx     <= 1'b0;
                new_game_ack_message_rx <= 1'b0;
            end else begin
                new_message_received <= new_message_received;
            end
        end
    end

endmodule
